// File: rtl/seg_scan_pkg.sv
// Shared definitions for the multiplexed 7-segment scan driver.
// Holds the segment width, the all-off code and the packed digit extractor.
package seg_scan_pkg;

  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Widest digit count the extractor accepts; callers zero-pad up to this.
  localparam int MAX_DIGITS = 32;

  function automatic logic [SEG_W-1:0] seg_digit(
    input logic [MAX_DIGITS*SEG_W-1:0] codes,
    input logic [31:0]                 i
  );
    return codes[i*SEG_W +: SEG_W];
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Digit-slot prescaler: div_cnt counts 0..SCAN_DIV-1 and tick marks the last cycle of a slot.
module scan_prescaler #(
  parameter int SCAN_DIV = 1000,
  parameter int DIV_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [DIV_W-1:0] div_cnt_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             tick;

  assign tick      = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  assign div_cnt_o = div_cnt_q;
  assign tick_o    = tick;

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment driver with a double-buffered frame applied only at frame boundaries.
// Optional inter-digit blanking is enabled by defining SEG_SCAN_DEADTIME_EN.
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int DEAD_CYCLES = 50
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_DIGITS*SEG_W-1:0] in_seg,
  input  logic [NUM_DIGITS-1:0]       in_blank,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic                        frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV),
    .DIV_W    (DIV_W)
  ) u_prescaler (
    .clk_i     (clk),
    .rst_i     (rst),
    .div_cnt_o (div_cnt),
    .tick_o    (tick)
  );

  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        last_digit;
  logic                        frame_end;
  logic                        accept;

  logic [NUM_DIGITS*SEG_W-1:0] pend_seg_q;
  logic [NUM_DIGITS-1:0]       pend_blank_q;
  logic                        pend_full_q, pend_full_d;

  logic [NUM_DIGITS*SEG_W-1:0] disp_seg_q;
  logic [NUM_DIGITS-1:0]       disp_blank_q;

  logic [SEG_W-1:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0]       an_n_q, an_n_d;
  logic                        frame_done_q;

  assign last_digit = (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign frame_end  = tick && last_digit;
  assign in_ready   = !pend_full_q && !rst;
  assign accept     = in_valid && in_ready;

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
  end

  // A transfer and an accept never collide: in_ready is low whenever pending holds a frame.
  always_comb begin
    pend_full_d = pend_full_q;
    if (accept) begin
      pend_full_d = 1'b1;
    end else if (frame_end) begin
      pend_full_d = 1'b0;
    end
  end

  logic dead;
`ifdef SEG_SCAN_DEADTIME_EN
  assign dead = (32'(div_cnt) < DEAD_CYCLES);
`else
  logic unused_cfg;
  assign dead       = 1'b0;
  assign unused_cfg = (^div_cnt) ^ (DEAD_CYCLES > 0);
`endif

  logic [MAX_DIGITS*SEG_W-1:0] disp_pad;
  logic [NUM_DIGITS-1:0]       onehot;

  always_comb begin
    disp_pad = '0;
    disp_pad[NUM_DIGITS*SEG_W-1:0] = disp_seg_q;
    onehot = '0;
    onehot[idx_q] = 1'b1;
    seg_d  = disp_blank_q[idx_q] ? SEG_BLANK : seg_digit(disp_pad, 32'(idx_q));
    an_n_d = ~onehot;
    if (dead) begin
      seg_d  = SEG_BLANK;
      an_n_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      pend_full_q  <= 1'b0;
      disp_seg_q   <= {NUM_DIGITS{SEG_BLANK}};
      disp_blank_q <= '1;
      seg_q        <= SEG_BLANK;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pend_full_q  <= pend_full_d;
      if (frame_end && pend_full_q) begin
        disp_seg_q   <= pend_seg_q;
        disp_blank_q <= pend_blank_q;
      end
      seg_q        <= seg_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_end;
    end
  end

  // Pending payload is qualified by pend_full, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pend_seg_q   <= in_seg;
      pend_blank_q <= in_blank;
    end
  end

  assign seg        = seg_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule
